// File: rtl/mst_fifo_pref.sv
// Per-channel prefetch buffers that feed the FT601 master write path.
// Each channel fills from the internal loopback FIFO or from an incrementing pattern.
//
// state  | meaning
// FIDLE  | no fill, waiting for prefena
// FILL   | master in write state, fill channel prefchn
// FFLUSH | one cycle, clear all buffers, stream counters and in-flight read
module mst_fifo_pref #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prefena,
  input  logic        prefreq,
  input  logic        prefmod,
  input  logic [1:0]  prefchn,
  output logic [3:0]  prefnempt,
  output logic [35:0] prefdout,
  input  logic [3:0]  ififonempt,
  input  logic [35:0] ififo_rdat,
  output logic        ififord,
  output logic [1:0]  ififordid
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {FIDLE, FILL, FFLUSH} fst_t;

  fst_t          st, st_nxt;
  logic          prefmod_q;
  logic          infl;
  logic [1:0]    tag;
  logic [AW:0]   cnt  [4];
  logic [AW-1:0] wptr [4];
  logic [AW-1:0] rptr [4];
  logic [31:0]   scnt [4];
  logic [35:0]   mem  [4][DEPTH];

  logic          mode_chg;
  logic          filling;
  logic [AW+1:0] occ_sel;
  logic          space_sel;
  logic          sw;
  logic [35:0]   wdat;
  logic [3:0]    push;
  logic [3:0]    pop;

  assign mode_chg = prefmod ^ prefmod_q;
  assign filling  = (st == FILL) && prefena;

  // An in-flight read already owns a slot in its target channel.
  always_comb begin
    occ_sel   = {1'b0, cnt[prefchn]} + {{(AW+1){1'b0}}, (infl && (tag == prefchn))};
    space_sel = occ_sel < (AW+2)'(DEPTH);
  end

  assign ififord   = filling && !prefmod && ififonempt[prefchn] && space_sel;
  assign ififordid = ififord ? prefchn : 2'd0;
  // A returning loopback word wins the single write port.
  assign sw        = filling && prefmod && space_sel && !infl;
  assign wdat      = infl ? ififo_rdat : {4'hF, scnt[prefchn]};

  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < 4; c++) begin
      push[c]      = (infl && (tag == 2'(c))) || (sw && (prefchn == 2'(c)));
      pop[c]       = prefreq && (prefchn == 2'(c)) && (cnt[c] != '0);
      prefnempt[c] = cnt[c] != '0;
    end
  end

  assign prefdout = prefnempt[prefchn] ? mem[prefchn][rptr[prefchn]] : 36'h0;

  always_comb begin
    st_nxt = st;
    case (st)
      FIDLE:   if (mode_chg) st_nxt = FFLUSH;
               else if (prefena) st_nxt = FILL;
      FILL:    if (mode_chg) st_nxt = FFLUSH;
               else if (!prefena) st_nxt = FIDLE;
      FFLUSH:  st_nxt = FIDLE;
      default: st_nxt = FIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FIDLE;
      prefmod_q <= 1'b0;
      infl      <= 1'b0;
      tag       <= 2'd0;
      for (int c = 0; c < 4; c++) begin
        cnt[c]  <= '0;
        wptr[c] <= '0;
        rptr[c] <= '0;
        scnt[c] <= '0;
      end
    end else begin
      st        <= st_nxt;
      prefmod_q <= prefmod;
      if (st == FFLUSH) begin
        infl <= 1'b0;
        for (int c = 0; c < 4; c++) begin
          cnt[c]  <= '0;
          wptr[c] <= '0;
          rptr[c] <= '0;
          scnt[c] <= '0;
        end
      end else begin
        infl <= ififord;
        if (ififord) tag <= prefchn;
        for (int c = 0; c < 4; c++) begin
          if (push[c]) wptr[c] <= wptr[c] + 1'b1;
          if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
          if (push[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
          else if (!push[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
          if (sw && (prefchn == 2'(c))) scnt[c] <= scnt[c] + 32'd1;
        end
      end
    end
  end

  // Storage needs no reset; contents are only visible through cnt.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (push[c]) mem[c][wptr[c]] <= wdat;
    end
  end

endmodule

// File: tb/tb_mst_fifo_pref.sv
// Directed bench for mst_fifo_pref with a small per-channel internal FIFO model.
module tb_mst_fifo_pref;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prefena = 1'b0;
  logic        prefreq = 1'b0;
  logic        prefmod = 1'b0;
  logic [1:0]  prefchn = 2'd0;
  logic [3:0]  prefnempt;
  logic [35:0] prefdout;
  logic [3:0]  ififonempt = 4'h0;
  logic [35:0] ififo_rdat = 36'h0;
  logic        ififord;
  logic [1:0]  ififordid;

  always #5 clk = ~clk;

  mst_fifo_pref #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prefena    (prefena),
    .prefreq    (prefreq),
    .prefmod    (prefmod),
    .prefchn    (prefchn),
    .prefnempt  (prefnempt),
    .prefdout   (prefdout),
    .ififonempt (ififonempt),
    .ififo_rdat (ififo_rdat),
    .ififord    (ififord),
    .ififordid  (ififordid)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] sword(input int i);
    return {4'hF, 32'(i)};
  endfunction

  // Internal FIFO model: a read seen before an edge returns its word in the next cycle.
  logic [35:0] fmem [4][16];
  int          fhd [4];
  int          ftl [4];
  logic        rd_pend = 1'b0;
  logic [1:0]  rd_id = 2'd0;
  int          rd_tot = 0;
  int          rd_ch2 = 0;
  int          cnt_max = 0;

  task automatic fpush(input int c, input logic [35:0] d);
    fmem[c][ftl[c]] = d;
    ftl[c]++;
  endtask

  always begin
    @(negedge clk);
    if (rd_pend) begin
      if (fhd[rd_id] != ftl[rd_id]) begin
        ififo_rdat = fmem[rd_id][fhd[rd_id]];
        fhd[rd_id]++;
      end else begin
        ififo_rdat = 36'hE_DEADBEEF;
      end
    end
    for (int c = 0; c < 4; c++) begin
      ififonempt[c] = (fhd[c] != ftl[c]);
      if (int'(dut.cnt[c]) > cnt_max) cnt_max = int'(dut.cnt[c]);
    end
    #4;
    rd_pend = ififord;
    rd_id   = ififordid;
    if (ififord) begin
      rd_tot++;
      if (ififordid == 2'd2) rd_ch2++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  localparam logic [35:0] WA = 36'h1_AAAA0001;
  localparam logic [35:0] WB = 36'h2_BBBB0002;
  localparam logic [35:0] WC = 36'h3_CCCC0003;
  localparam logic [35:0] WD = 36'h5_DDDD0005;

  initial begin
    // reset state, with inputs that would otherwise request a read
    tick(2);
    prefchn = 2'd2;
    prefena = 1'b1;
    #1;
    chk_val("rst_nempt", 36'(prefnempt), 36'h0);
    chk_val("rst_dout",  prefdout,        36'h0);
    chk_val("rst_rd",    36'(ififord),    36'h0);
    chk_val("rst_rdid",  36'(ififordid),  36'h0);
    prefchn = 2'd0;
    prefena = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // stream on channel 0, popping every cycle from cycle 2
    prefmod = 1'b1;
    tick(3);
    prefchn = 2'd0;
    prefena = 1'b1;
    tick(1);
    chk_val("st_c1_nempt", 36'(prefnempt), 36'h0);
    tick(1);
    chk_val("st_c2_nempt", 36'(prefnempt), 36'h1);
    chk_val("st_dout0", prefdout, sword(0));
    prefreq = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_val("st_seq", prefdout, sword(i));
    end
    prefreq = 1'b0;
    prefena = 1'b0;
    tick(1);
    chk_val("st_hold", prefdout, sword(5));

    // full: channel 2 stops at DEPTH, one pop gives exactly one refill
    prefchn = 2'd2;
    prefena = 1'b1;
    tick(8);
    chk_val("full_nempt", 36'(prefnempt), 36'h5);
    chk_val("full_head", prefdout, sword(0));
    prefreq = 1'b1;
    tick(1);
    prefreq = 1'b0;
    chk_val("full_pop_head", prefdout, sword(1));
    tick(3);
    prefena = 1'b0;
    prefreq = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk_val("full_drain", prefdout, sword(i));
      tick(1);
    end
    prefreq = 1'b0;
    chk_val("full_empty", 36'(prefnempt), 36'h1);

    // flush with channels 0 and 1 holding data
    prefchn = 2'd1;
    prefena = 1'b1;
    tick(3);
    prefena = 1'b0;
    tick(1);
    chk_val("fl_pre", 36'(prefnempt), 36'h3);
    prefmod = 1'b0;
    tick(1);
    chk_val("fl_n1", 36'(prefnempt), 36'h3);
    tick(1);
    chk_val("fl_n2", 36'(prefnempt), 36'h0);
    prefmod = 1'b1;
    tick(3);
    prefchn = 2'd0;
    prefena = 1'b1;
    tick(2);
    chk_val("fl_restart", prefdout, sword(0));
    prefena = 1'b0;
    tick(1);

    // loopback from channel 2 internal FIFO
    prefmod = 1'b0;
    fpush(2, WA);
    fpush(2, WB);
    fpush(2, WC);
    tick(3);
    rd_tot = 0;
    rd_ch2 = 0;
    prefchn = 2'd2;
    prefena = 1'b1;
    tick(1);
    chk_val("lb_rd",   36'(ififord),   36'h1);
    chk_val("lb_rdid", 36'(ififordid), 36'h2);
    tick(1);
    chk_val("lb_c2", 36'(prefnempt), 36'h0);
    tick(1);
    chk_val("lb_c3", 36'(prefnempt), 36'h4);
    tick(5);
    chk_val("lb_nrd",   36'(rd_tot), 36'd3);
    chk_val("lb_nrd2",  36'(rd_ch2), 36'd3);
    chk_val("lb_nempt", 36'(prefnempt), 36'h4);
    prefena = 1'b0;
    prefreq = 1'b1;
    chk_val("lb_pop_a", prefdout, WA);
    tick(1);
    chk_val("lb_pop_b", prefdout, WB);
    tick(1);
    chk_val("lb_pop_c", prefdout, WC);
    tick(1);
    prefreq = 1'b0;
    chk_val("lb_empty", 36'(prefnempt), 36'h0);

    // channel switch while a channel 1 read is in flight
    fpush(1, WD);
    tick(1);
    prefchn = 2'd1;
    prefena = 1'b1;
    tick(1);
    chk_val("sw_rd",   36'(ififord),   36'h1);
    chk_val("sw_rdid", 36'(ififordid), 36'h1);
    tick(1);
    prefchn = 2'd3;
    tick(1);
    chk_val("sw_nempt", 36'(prefnempt), 36'h2);
    chk_val("sw_dout3", prefdout, 36'h0);
    prefena = 1'b0;
    prefchn = 2'd1;
    #1;
    chk_val("sw_dout1", prefdout, WD);
    prefreq = 1'b1;
    tick(1);
    prefreq = 1'b0;
    chk_val("sw_pop", 36'(prefnempt), 36'h0);

    // async reset during back-to-back reads
    fpush(2, 36'h6_00000010);
    fpush(2, 36'h6_00000011);
    fpush(2, 36'h6_00000012);
    fpush(2, 36'h6_00000013);
    tick(1);
    prefchn = 2'd2;
    prefena = 1'b1;
    tick(3);
    chk_val("rs_pre", 36'(prefnempt), 36'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("rs_nempt", 36'(prefnempt), 36'h0);
    chk_val("rs_dout",  prefdout,        36'h0);
    chk_val("rs_rd",    36'(ififord),    36'h0);
    chk_val("rs_rdid",  36'(ififordid),  36'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_val("rs_nowr", 36'(prefnempt), 36'h0);
    tick(1);
    chk_val("rs_c2", 36'(prefnempt), 36'h0);
    tick(1);
    chk_val("rs_w2", prefdout, 36'h6_00000012);
    prefena = 1'b0;
    tick(2);

    chk_val("cnt_max", 36'(cnt_max), 36'(DEPTH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mst_fifo_pref.md
# mst_fifo_pref

Prefetch buffer between the internal loopback FIFOs and the FT601 master FIFO state machine. It supplies the master's write path through `prefdout` and `prefnempt`. There is one first-word-fall-through buffer per channel (4 channels), filled either from the internal FIFO read port (loopback mode) or from a per-channel incrementing pattern generator (streaming mode). Filling runs only while the master holds `prefena`, and always targets the channel on `prefchn`.

## Interface
- `DEPTH`, default 4: entries per channel buffer. Power of two, at least 2.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `prefena` in 1: fill enable; the master is in its write state.
- `prefreq` in 1: pop head of channel `prefchn`.
- `prefmod` in 1: 1 = streaming pattern, 0 = loopback from internal FIFO.
- `prefchn` in 2: active channel.
- `prefnempt` out 4: per-channel buffer not empty.
- `prefdout` out 36: head of `prefchn` buffer, as {be[3:0], data[31:0]}.
- `ififonempt` in 4: internal FIFO per-channel not empty.
- `ififo_rdat` in 36: internal FIFO read data, valid 1 cycle after `ififord`.
- `ififord` out 1: internal FIFO read strobe.
- `ififordid` out 2: channel read by `ififord`.

## Operation
- Fill-engine states:
  - FIDLE
    - Go to FILL when `prefena`=1.
    - Go to FFLUSH when `prefmod` differs from its registered copy `prefmod_q`.
  - FILL
    - Go to FIDLE when `prefena`=0.
    - Go to FFLUSH on a `prefmod` change.
    - FFLUSH has priority over all other transitions.
  - FFLUSH
    - Lasts one cycle, then goes to FIDLE.
    - Clears all counts and pointers, zeroes all 4 stream counters, and discards any in-flight read.
- Space for channel c means `cnt[c] + (infl & tag==c) < DEPTH`. A pop in the same cycle is not counted.
- Loopback fill:
  - `ififord` = FILL & `prefena` & !`prefmod` & `ififonempt[prefchn]` & space(`prefchn`). This is combinational.
  - `ififordid` = `prefchn`.
  - On each read, set `infl` and set `tag` = `prefchn`.
  - On the next cycle, write `ififo_rdat` into buffer[`tag`], even if `prefchn` or `prefena` has changed since.
  - Back-to-back reads are allowed, one per cycle.
- Stream fill:
  - In FILL & `prefena` & `prefmod` & space(`prefchn`), write {4'hF, `scnt[prefchn]`} into buffer[`prefchn`].
  - Then increment `scnt[prefchn]`, modulo 2^32.
  - At most one write per cycle.
- Pop:
  - `prefreq` & `prefnempt[prefchn]` advances the read pointer of `prefchn`.
  - `prefreq` on an empty channel is ignored.
- Simultaneous push and pop on the same channel leaves `cnt` unchanged, and the data order is preserved.
- `prefnempt[c]` = (`cnt[c]` != 0), registered through the count.
- `prefdout` = head of `prefchn` when `prefnempt[prefchn]`, otherwise 36'h0. This is combinational on `prefchn`.
- `cnt` never exceeds DEPTH. A write to a full buffer is impossible by construction; the bench asserts this.

## Timing
- Reset values:
  - `prefnempt`=0, `prefdout`=0, `ififord`=0, `ififordid`=0.
  - State FIDLE; all `cnt`, pointers, `scnt`, `infl` = 0; `prefmod_q` = `prefmod` reset value 0.
- Reset mid-operation: everything clears immediately. An in-flight read's data is dropped, and any words already taken from the internal FIFO are lost.
- Loopback latency:
  - `prefena` sampled 1 at cycle 0 → state FILL in cycle 1.
  - `ififord` in cycle 1.
  - Data captured at the end of cycle 2.
  - `prefnempt` = 1 in cycle 3.
- Stream latency:
  - FILL in cycle 1 → write at the end of cycle 1 → `prefnempt` = 1 in cycle 2.
  - Sustained rate is 1 word per cycle with `prefreq` held.
- Pop: the next head appears on `prefdout` in the cycle after the pop. If the buffer becomes empty, `prefnempt` falls in that same next cycle.
- Mode change:
  - `prefmod` toggles in cycle N → FFLUSH in cycle N+1.
  - `prefnempt`=0 from cycle N+2.
  - Fill restarts no earlier than cycle N+3.

## Test plan
- Stream: `prefmod`=1, `prefchn`=0, `prefena`=1, `prefreq`=1 from cycle 2. Required: `prefdout` = 36'hF_00000000, F_00000001, F_00000002, … one per cycle with no gaps.
- Loopback: channel 2 FIFO holds A, B, C; `prefchn`=2, `prefena`=1, `prefreq`=0. Required: exactly 3 `ififord` pulses with `ififordid`=2; `prefnempt`=4'b0100; pops return A, B, C.
- Full: DEPTH=4, stream, `prefreq`=0. Required: fill stops after 4 words (`scnt[0]`=4). A single pop triggers exactly one refill, with data F_00000004 at the tail.
- Channel switch with read in flight: `ififord` for channel 1 at cycle k, `prefchn`=3 at k+1. Required: the returned word lands in channel 1, so `prefnempt[1]`=1 and `prefnempt[3]`=0.
- Flush: channels 0 and 1 non-empty, then toggle `prefmod`. Required: `prefnempt`=0 two cycles later; the next stream word is F_00000000.
- Async reset mid-fill: assert `rst_n`=0 during back-to-back reads. Required: all outputs are 0 immediately, and no write occurs on the cycle after release.
